and_gate_seq_ctrl: RTL and testbench

//   Sequencer/checker for the N-input AND gate datapath. On start it walks
//   dut_in through every input combination in ascending binary order and

---
 rtl/and_gate_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_and_gate_seq_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/and_gate_seq_ctrl.sv
// Self-test sequencer for an N-input AND gate: walks every input vector, checks the gate output, reports pass/fail.
// Optional build macro AND_SEQ_STOP_ON_ERR_EN ends the run on the first mismatch.
module and_gate_seq_ctrl #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned DWELL = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            dut_out,
    output logic [N_IN-1:0] dut_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] vec_idx
);

    localparam int unsigned   CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned   ERR_W    = N_IN + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};
`ifdef AND_SEQ_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_FINISH
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_IN-1:0]     r_vec;
    logic [N_IN-1:0]     w_vec_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [ERR_W-1:0]    r_err;
    logic [ERR_W-1:0]    w_err_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_pass;
    logic                w_pass_nxt;

    logic                w_mismatch;
    logic [ERR_W-1:0]    w_err_upd;
    logic                w_sample;

    assign w_mismatch = (dut_out != (&r_vec));
    assign w_err_upd  = r_err + ERR_W'(w_mismatch);
    assign w_sample   = (r_cnt == CNT_LAST);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    // Next-state and next-output logic; done is registered on entry so it is high for the FINISH cycle
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_pass_nxt  = r_pass;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_APPLY;
                    w_vec_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = '0;
                    w_pass_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_APPLY: begin
                if (!w_sample) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_err_nxt = w_err_upd;
                    if ((r_vec == VEC_LAST) || (STOP_ON_ERR && w_mismatch)) begin
                        w_state_nxt = S_FINISH;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_pass_nxt  = (w_err_upd == '0);
                    end else begin
                        w_vec_nxt = r_vec + N_IN'(1);
                        w_cnt_nxt = '0;
                    end
                end
            end
            S_FINISH: begin
                // The edge closing the done cycle also accepts a held start, giving back-to-back runs
                w_state_nxt = S_IDLE;
                if (start) begin
                    w_state_nxt = S_APPLY;
                    w_vec_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = '0;
                    w_pass_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign dut_in  = r_vec;
    assign vec_idx = r_vec;
    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
    assign err_cnt = r_err;

endmodule

// File: tb/tb_and_gate_seq_ctrl.sv
// Scoreboard bench for and_gate_seq_ctrl: stimulus queues expected run results, a negedge monitor checks each done pulse.
module tb_and_gate_seq_ctrl;

    localparam int unsigned N_IN    = 3;
    localparam int unsigned DWELL   = 20;
    localparam int unsigned NVEC    = 1 << N_IN;
    localparam int unsigned RUN_LAT = NVEC * DWELL;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            fault = 1'b0;
    logic            dut_out;
    logic [N_IN-1:0] dut_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] vec_idx;

    typedef struct {
        int unsigned err;
        int unsigned pas;
        int unsigned vec;
        int unsigned lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    and_gate_seq_ctrl #(.N_IN(N_IN), .DWELL(DWELL)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .dut_out (dut_out),
        .dut_in  (dut_in),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt),
        .vec_idx (vec_idx)
    );

    // Gate under test: good AND or stuck-at-1
    assign dut_out = fault ? 1'b1 : (&dut_in);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_cnt, 0);
        check({tag, "_vec"}, vec_idx, 0);
        check({tag, "_dut_in"}, dut_in, 0);
    endtask

    // Monitor: vector sequencing, dwell length, and done-time scoreboard compare
    logic            prev_busy = 1'b0;
    logic            prev_done = 1'b0;
    int              t_start = 0;
    int              run_len = 0;
    logic [N_IN-1:0] last_vec = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (busy) begin
                if (dut_in != vec_idx) check("dut_in_eq_vec", dut_in, vec_idx);
                if (!prev_busy) begin
                    t_start  = cyc;
                    run_len  = 1;
                    last_vec = vec_idx;
                    check("run_first_vec", vec_idx, 0);
                    check("run_err_clear", err_cnt, 0);
                end else if (vec_idx == last_vec) begin
                    run_len++;
                end else begin
                    check("dwell", run_len, DWELL);
                    check("vec_step", vec_idx, N_IN'(last_vec + N_IN'(1)));
                    last_vec = vec_idx;
                    run_len  = 1;
                end
            end
            if (done) begin
                check("done_single", prev_done, 0);
                check("done_busy_low", busy, 0);
                check("dwell_last", run_len, DWELL);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done actual=1 required=0 (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("err_cnt", err_cnt, e.err);
                    check("pass", pass, e.pas);
                    check("vec_idx_end", vec_idx, e.vec);
                    check("latency", cyc - t_start, e.lat);
                end
            end
        end
        prev_busy = busy;
        prev_done = done;
    end

    task automatic push_exp(input int unsigned err, input int unsigned pas,
                            input int unsigned vec, input int unsigned lat);
        exp_t e;
        e.err = err; e.pas = pas; e.vec = vec; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int i;
        for (i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d required=0 pending", name, exp_q.size());
            exp_q.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_vec(input int unsigned v, input int budget);
        int i;
        for (i = 0; i < budget && vec_idx != N_IN'(v); i++) @(negedge clk);
        check("wait_vec", vec_idx, v);
    endtask

    initial begin
        // Reset with random start
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk) start = 1'($urandom_range(0, 1));
            #1 check_reset_vals("reset");
        end
        @(negedge clk) start = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("post_reset");

        // Good gate, full sweep
        fault = 1'b0;
        push_exp(0, 1, NVEC - 1, RUN_LAT);
        pulse_start();
        wait_drain("good_run", RUN_LAT + 50);

        // Stuck-at-1 gate
        fault = 1'b1;
`ifdef AND_SEQ_STOP_ON_ERR_EN
        push_exp(1, 0, 0, DWELL);
`else
        push_exp(NVEC - 1, 0, NVEC - 1, RUN_LAT);
`endif
        pulse_start();
        wait_drain("stuck_run", RUN_LAT + 50);
        fault = 1'b0;

        // start mid-run is ignored
        push_exp(0, 1, NVEC - 1, RUN_LAT);
        pulse_start();
        wait_vec(3, RUN_LAT);
        pulse_start();
        wait_drain("midstart_run", RUN_LAT + 50);

        // Reset mid-run: immediate clear, no done
        pulse_start();
        wait_vec(5, RUN_LAT);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midrun_reset");
        repeat (3) @(negedge clk);
        check_reset_vals("midrun_reset_hold");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_vals("after_midrun_reset");
        push_exp(0, 1, NVEC - 1, RUN_LAT);
        pulse_start();
        wait_drain("rerun", RUN_LAT + 50);

        // start held 400 clocks: back-to-back runs every RUN_LAT+1 edges
        push_exp(0, 1, NVEC - 1, RUN_LAT);
        push_exp(0, 1, NVEC - 1, RUN_LAT);
        push_exp(0, 1, NVEC - 1, RUN_LAT);
        @(negedge clk) start = 1'b1;
        repeat (400) @(posedge clk);
        @(negedge clk) start = 1'b0;
        wait_drain("b2b_runs", 3 * RUN_LAT + 50);

        repeat (30) @(negedge clk);
        check("final_idle_busy", busy, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
